// File: rtl/dwt_lift_step.sv
// One 9/7 lifting step, data_o = center + K*(left + right), as a 3-register valid/ready pipeline.
// A beat presented in cycle k is on data_o in cycle k+3; stalls freeze every stage, bubbles are kept.
module dwt_lift_step #(
    parameter int DataWidth = 16,
    parameter int DataPoint = 10,
    parameter int CoefWidth = 16,
    parameter int CoefPoint = 14,
    parameter int Coef      = -25987
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [DataWidth-1:0] left_i,
    input  logic signed [DataWidth-1:0] center_i,
    input  logic signed [DataWidth-1:0] right_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic signed [DataWidth-1:0] data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        sat_o
);

    localparam int SumWidth  = DataWidth + 1;
    localparam int ProdWidth = SumWidth + CoefWidth;
    localparam int ProdPoint = DataPoint + CoefPoint;
    // Product carries DataPoint+CoefPoint fraction bits; drop back to the sample point.
    localparam int Shift     = ProdPoint - DataPoint;

    localparam logic signed [CoefWidth-1:0] CoefVal   = CoefWidth'(Coef);
    localparam logic signed [ProdWidth-1:0] RoundBias = ProdWidth'(2 ** (Shift - 1));
    localparam logic signed [ProdWidth-1:0] SatMax    =
        {{(ProdWidth - DataWidth + 1){1'b0}}, {(DataWidth - 1){1'b1}}};
    localparam logic signed [ProdWidth-1:0] SatMin    =
        {{(ProdWidth - DataWidth + 1){1'b1}}, {(DataWidth - 1){1'b0}}};

    logic en;

    logic                        s1_vld;
    logic signed [SumWidth-1:0]  s1_sum;
    logic signed [DataWidth-1:0] s1_ctr;

    logic                        s2_vld;
    logic signed [ProdWidth-1:0] s2_prod;
    logic signed [DataWidth-1:0] s2_ctr;

    logic signed [ProdWidth-1:0] sum_ext;
    logic signed [ProdWidth-1:0] coef_ext;
    logic signed [ProdWidth-1:0] prod;

    logic signed [ProdWidth-1:0] rnd;
    logic signed [ProdWidth-1:0] shr;
    logic signed [ProdWidth-1:0] ctr_ext;
    logic signed [ProdWidth-1:0] res;
    logic                        sat_hi;
    logic                        sat_lo;
    logic signed [DataWidth-1:0] res_clamped;

    // The whole pipe moves together, so an empty output slot never lets upstream bubbles collapse.
    assign en      = !valid_o || ready_i;
    assign ready_o = en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld <= 1'b0;
            s1_sum <= '0;
            s1_ctr <= '0;
        end else if (en) begin
            s1_vld <= valid_i;
            s1_sum <= {left_i[DataWidth-1], left_i} + {right_i[DataWidth-1], right_i};
            s1_ctr <= center_i;
        end
    end

    always_comb begin
        sum_ext  = {{CoefWidth{s1_sum[SumWidth-1]}}, s1_sum};
        coef_ext = {{SumWidth{CoefVal[CoefWidth-1]}}, CoefVal};
        prod     = sum_ext * coef_ext;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_vld  <= 1'b0;
            s2_prod <= '0;
            s2_ctr  <= '0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_prod <= prod;
            s2_ctr  <= s1_ctr;
        end
    end

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    always_comb begin
        rnd     = s2_prod + RoundBias;
        shr     = rnd >>> Shift;
        ctr_ext = {{(ProdWidth - DataWidth){s2_ctr[DataWidth-1]}}, s2_ctr};
        res     = shr + ctr_ext;
        sat_hi  = res > SatMax;
        sat_lo  = res < SatMin;
        if (sat_hi) begin
            res_clamped = {1'b0, {(DataWidth - 1){1'b1}}};
        end else if (sat_lo) begin
            res_clamped = {1'b1, {(DataWidth - 1){1'b0}}};
        end else begin
            res_clamped = res[DataWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sat_o   <= 1'b0;
        end else if (en) begin
            valid_o <= s2_vld;
            data_o  <= res_clamped;
            sat_o   <= sat_hi || sat_lo;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) valid_o |-> !$isunknown(data_o));

endmodule

// File: tb/tb_dwt_lift_step.sv
// Bench for dwt_lift_step: vector table, hand-built stall/reset sequences and a random scoreboard run.
module tb_dwt_lift_step;

    logic               clk_i;
    logic               rst_i;
    logic signed [15:0] left_i, center_i, right_i;
    logic               valid_i, ready_i;
    logic               ready_o, valid_o, sat_o;
    logic signed [15:0] data_o;
    logic               ready_p, valid_p, sat_p;
    logic signed [15:0] data_p;

    dwt_lift_step dut (
        .clk_i(clk_i), .rst_i(rst_i), .left_i(left_i), .center_i(center_i), .right_i(right_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .sat_o(sat_o)
    );

    dwt_lift_step #(.Coef(25987)) dut_pos (
        .clk_i(clk_i), .rst_i(rst_i), .left_i(left_i), .center_i(center_i), .right_i(right_i),
        .valid_i(valid_i), .ready_o(ready_p), .data_o(data_p), .valid_o(valid_p),
        .ready_i(ready_i), .sat_o(sat_p)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic signed [15:0] l, c, r, nd;
        logic               ns;
        logic signed [15:0] pd;
        logic               ps;
    } vec_t;

    typedef struct packed {
        logic signed [15:0] nd;
        logic               ns;
        logic signed [15:0] pd;
        logic               ps;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [16:0] model(input logic signed [15:0] l, c, r, input longint coef);
        longint s, p, q, v;
        s = longint'(l) + longint'(r);
        p = s * coef;
        q = (p + 64'sd8192) >>> 14;
        v = q + longint'(c);
        if (v > 32767) return {1'b1, 16'h7fff};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    // Scoreboard: push on accept, pop and compare on every emitted beat.
    always @(negedge clk_i) begin
        logic [16:0] mn, mp;
        exp_t e;
        if (rst_i) begin
            sb_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    pops++;
                    chk("sb_data_neg", data_o, e.nd);
                    chk("sb_sat_neg", sat_o, e.ns);
                    chk("sb_valid_pos", valid_p, 1);
                    chk("sb_data_pos", data_p, e.pd);
                    chk("sb_sat_pos", sat_p, e.ps);
                end
            end
            if (valid_i && ready_o) begin
                mn = model(left_i, center_i, right_i, -25987);
                mp = model(left_i, center_i, right_i, 25987);
                e.nd = mn[15:0]; e.ns = mn[16];
                e.pd = mp[15:0]; e.ps = mp[16];
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_rand;
        left_i   = 16'($urandom);
        center_i = 16'($urandom);
        right_i  = 16'($urandom);
    endtask

    task automatic apply_vec(input vec_t v);
        tick;
        left_i = v.l; center_i = v.c; right_i = v.r;
        valid_i = 1'b1; ready_i = 1'b1;
        tick;
        valid_i = 1'b0;
        tick;
        @(negedge clk_i);
        chk("vec_valid_early", valid_o, 0);
        tick;
        @(negedge clk_i);
        chk("vec_valid", valid_o, 1);
        chk("vec_data_neg", data_o, v.nd);
        chk("vec_sat_neg", sat_o, v.ns);
        chk("vec_data_pos", data_p, v.pd);
        chk("vec_sat_pos", sat_p, v.ps);
    endtask

    initial begin
        logic [15:0] hist;
        logic [16:0] m0;
        int          pops0, stale, acc, cyc;

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        left_i = '0; center_i = '0; right_i = '0;

        vecs[0] = '{16'sd1024, 16'sd0, 16'sd1024, -16'sd3248, 1'b0, 16'sd3248, 1'b0};
        vecs[1] = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sh8000, 1'b1, 16'sh7fff, 1'b1};
        vecs[2] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0};
        vecs[3] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh7fff, 1'b1, 16'sh8000, 1'b1};
        vecs[4] = '{16'sd1, 16'sd0, 16'sd0, -16'sd2, 1'b0, 16'sd2, 1'b0};
        vecs[5] = '{-16'sd1, 16'sd0, 16'sd0, 16'sd2, 1'b0, -16'sd2, 1'b0};
        vecs[6] = '{16'sd512, 16'sd1000, 16'sd0, 16'sd188, 1'b0, 16'sd1812, 1'b0};
        vecs[7] = '{16'sd8192, 16'sd0, 16'sd0, -16'sd12993, 1'b0, 16'sd12994, 1'b0};

        // Reset state
        tick; tick;
        @(negedge clk_i);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_sat", sat_o, 0);
        tick;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", ready_o, 1);
        chk("rst_ready_pos", ready_p, 1);

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // Eight back-to-back beats must come out as eight consecutive valid cycles.
        tick;
        hist = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < 8) begin
                drive_rand;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            hist[j] = valid_o;
            tick;
        end
        chk("stream_valid_pattern", hist, 16'h07f8);
        chk("stream_drained", sb_q.size(), 0);

        // Full pipe held off for five cycles.
        pops0 = pops;
        ready_i = 1'b1;
        drive_rand;
        valid_i = 1'b1;
        m0 = model(left_i, center_i, right_i, -25987);
        tick; drive_rand;
        tick; drive_rand;
        tick;
        ready_i = 1'b0;
        drive_rand;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk_i);
            chk("stall_ready", ready_o, 0);
            chk("stall_valid", valid_o, 1);
            chk("stall_data", data_o, m0[15:0]);
            chk("stall_sat", sat_o, m0[16]);
            tick;
        end
        ready_i = 1'b1;
        tick; drive_rand;
        tick; drive_rand;
        tick;
        valid_i = 1'b0;
        repeat (8) tick;
        @(negedge clk_i);
        chk("stall_beats_out", pops - pops0, 6);
        chk("stall_drained", sb_q.size(), 0);

        // Reset with three beats in flight.
        for (int j = 0; j < 3; j++) begin
            tick;
            drive_rand;
            valid_i = 1'b1;
        end
        tick;
        valid_i = 1'b0;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_ready", ready_o, 1);
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            @(negedge clk_i);
            if (valid_o || valid_p) stale++;
        end
        chk("midrst_no_stale", stale, 0);
        apply_vec(vecs[6]);

        // Random handshakes against the model.
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            tick;
            drive_rand;
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 7);
            @(negedge clk_i);
            if (valid_i && ready_o) acc++;
            cyc++;
        end
        chk("rand_accepted", acc, 10000);
        tick;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (6) tick;
        @(negedge clk_i);
        chk("rand_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
